prog_counter_gen2: RTL

Parametrised successor to the team's 8-bit programmable up/down counter. Adds:
- configurable width;
- a programmable clock prescaler;
- four terminal-count modes (wrap, saturate, one-shot, auto-reload);
- a registered terminal-count pulse;
- a compare-match flag.

It sits between the pad-level control inputs and the output mux, and serves as the general timer/counter primitive for later designs.

---
 rtl/prog_counter_gen2.sv | 93 +++++++++
 1 files changed

// File: rtl/prog_counter_gen2.sv
// Parametrised programmable up/down counter with prescaler, four terminal-count
// modes, a registered terminal-count pulse and a compare-match flag.
module prog_counter_gen2 #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  enable,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      reload_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      cmp_val,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  cmp_match,
    output logic                  done
);

    localparam logic [1:0] MODE_WRAP     = 2'b00;
    localparam logic [1:0] MODE_SATURATE = 2'b01;
    localparam logic [1:0] MODE_ONE_SHOT = 2'b10;
    localparam logic [1:0] MODE_RELOAD   = 2'b11;

    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  tc_q, tc_d;
    logic                  done_q, done_d;
    logic [WIDTH-1:0]      term_val;
    logic                  at_term;
    logic                  tick;

    assign term_val = dir ? '0 : '1;
    assign at_term  = (count_q == term_val);

    always_comb begin
        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
        tc_d      = 1'b0;
        done_d    = done_q;
        tick      = 1'b0;
        if (load) begin
            count_d   = load_val;
            pre_cnt_d = '0;
            done_d    = 1'b0;
        end else if (enable && !done_q) begin
            // >= so that lowering prescale below pre_cnt fires on the next cycle
            if (pre_cnt_q >= prescale) begin
                tick      = 1'b1;
                pre_cnt_d = '0;
            end else begin
                pre_cnt_d = pre_cnt_q + 1'b1;
            end
            if (tick) begin
                if (at_term) begin
                    tc_d = 1'b1;
                    unique case (mode)
                        MODE_WRAP:     count_d = dir ? '1 : '0;
                        MODE_SATURATE: count_d = count_q;
                        MODE_ONE_SHOT: done_d  = 1'b1;
                        MODE_RELOAD:   count_d = reload_val;
                        default:       count_d = count_q;
                    endcase
                end else begin
                    count_d = dir ? count_q - 1'b1 : count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            pre_cnt_q <= '0;
            tc_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            pre_cnt_q <= pre_cnt_d;
            tc_q      <= tc_d;
            done_q    <= done_d;
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign done      = done_q;
    assign cmp_match = (count_q == cmp_val);

endmodule
